// File: rtl/core_pkg.sv
// Shared core constants: instruction/address widths, reset fetch address and
// the sequential PC step.
package core_pkg;

    localparam int          INSTR_W      = 32;
    localparam int          ADDR_W       = 32;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_INC       = 4;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with a synchronous flush. The caller guarantees
// that it never pushes while full (without a pop) and never pops while empty.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;

    // Pointers and count; flush empties the queue but keeps the storage contents.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Storage write; a push in a flush cycle is discarded.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

endmodule

// File: rtl/fetch_prefetch.sv
// Prefetching fetch stage. Requests instruction words ahead of decode, keeps
// returned words with their PCs in a small FIFO, and restarts on redirect.
//
// Handshakes:
//   imem: a request is presented with imem_req_o/imem_addr_o and is taken in
//         any cycle where imem_req_o && imem_gnt_i. Once raised, the request
//         and its address hold until granted, except in a redirect cycle where
//         it is withdrawn. Responses (imem_rvalid_i) come back in grant order.
//   decode: an instruction transfers in any cycle where instr_valid_o &&
//         instr_ready_i; instr_o/pc_o are stable while valid is held.
// A request is only raised when FIFO entries plus in-flight reads leave room,
// so every response always has a slot waiting for it.
module fetch_prefetch
    import core_pkg::*;
#(
    parameter int                    DATA_WIDTH = INSTR_W,
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    DEPTH      = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       redirect_i,
    input  logic [ADDR_WIDTH-1:0]      redirect_pc_i,
    output logic                       imem_req_o,
    output logic [ADDR_WIDTH-1:0]      imem_addr_o,
    input  logic                       imem_gnt_i,
    input  logic                       imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]      imem_rdata_i,
    output logic                       instr_valid_o,
    input  logic                       instr_ready_i,
    output logic [DATA_WIDTH-1:0]      instr_o,
    output logic [ADDR_WIDTH-1:0]      pc_o,
    output logic [ADDR_WIDTH-1:0]      pc_plus4_o,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

    localparam int                    CW  = $clog2(DEPTH + 1);
    localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(PC_INC);

    logic [ADDR_WIDTH-1:0]            fetch_pc;
    logic [ADDR_WIDTH-1:0]            resp_pc;
    logic [CW-1:0]                    outstanding;
    logic [CW-1:0]                    discard;
    logic [CW-1:0]                    count;
    logic [CW:0]                      inflight;
    logic                             issue;
    logic                             keep;
    logic                             pop;
    logic                             empty;
    logic                             full;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    // Reserve a FIFO slot for every read in flight; reset holds the request low.
    assign inflight      = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_o    = rst && !full && (inflight < (CW+1)'(DEPTH)) && !redirect_i;
    assign imem_addr_o   = fetch_pc;
    assign issue         = imem_req_o && imem_gnt_i;
    // Responses still owed to a flushed stream are dropped until discard drains.
    assign keep          = imem_rvalid_i && !redirect_i && (discard == '0);
    assign instr_valid_o = !empty && !redirect_i;
    assign pop           = instr_valid_o && instr_ready_i;

    // Request and response PCs; a redirect restarts both streams at the target.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect_i) begin
            fetch_pc <= redirect_pc_i;
            resp_pc  <= redirect_pc_i;
        end else begin
            if (issue) fetch_pc <= fetch_pc + INC;
            if (keep)  resp_pc  <= resp_pc + INC;
        end
    end

    // In-flight and to-be-dropped counters; discard is always rebuilt from outstanding.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding + CW'(issue) - CW'(imem_rvalid_i);
            if (redirect_i) begin
                discard <= outstanding - CW'(imem_rvalid_i);
            end else if (imem_rvalid_i && (discard != '0)) begin
                discard <= discard - 1'b1;
            end
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ADDR_WIDTH + DATA_WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (keep),
        .pop   (pop),
        .flush (redirect_i),
        .wdata ({resp_pc, imem_rdata_i}),
        .rdata (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign pc_o        = head[ADDR_WIDTH+DATA_WIDTH-1 -: ADDR_WIDTH];
    assign instr_o     = head[DATA_WIDTH-1:0];
    assign pc_plus4_o  = pc_o + INC;
    assign occupancy_o = count;

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: behavioural in-order memory with programmable
// latency, per-cycle vector table for the start-up/stall sequence, and a
// scoreboard of expected PCs for everything delivered to decode.
module tb_fetch_prefetch;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DEPTH = 4;
    localparam int CW    = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic          redirect;
    logic [AW-1:0] redirect_pc;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [DW-1:0] imem_rdata;
    logic          instr_valid;
    logic          instr_ready;
    logic [DW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] pc_plus4;
    logic [CW-1:0] occupancy;

    fetch_prefetch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .instr_o       (instr),
        .pc_o          (pc),
        .pc_plus4_o    (pc_plus4),
        .occupancy_o   (occupancy)
    );

    // ---------------- memory model / scoreboard state ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] addr;
    } mem_req_t;

    typedef struct {
        logic          ready;
        logic          exp_req;
        logic [AW-1:0] exp_addr;
        logic          exp_valid;
        logic [AW-1:0] exp_pc;
        logic [CW-1:0] exp_occ;
    } vec_t;

    mem_req_t      mem_q[$];
    logic [AW-1:0] exp_q[$];
    vec_t          vecs[14];

    int            checks    = 0;
    int            errors    = 0;
    int            cyc       = 0;
    int            lat       = 1;
    int            delivered = 0;
    logic          prev_stall = 1'b0;
    logic [AW-1:0] prev_addr  = '0;

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic restart_stream(input logic [AW-1:0] start);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(start + AW'(4 * i));
    endtask

    // ---------------- driver tasks ----------------
    // Entered just after a rising edge with this cycle's inputs already set;
    // drives the memory response, then observes at the falling edge.
    task automatic begin_cycle();
        mem_req_t      m;
        logic [AW-1:0] e;
        int            out_tb;
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mem_q[0].addr);
            void'(mem_q.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        @(negedge clk);
        if (prev_stall && !redirect) begin
            chk("req_hold", imem_req, 1'b1);
            chk("addr_hold", imem_addr, prev_addr);
        end
        prev_stall = imem_req && !imem_gnt;
        prev_addr  = imem_addr;
        out_tb = mem_q.size() + int'(imem_rvalid);
        chk("inflight_bound", (int'(occupancy) + out_tb <= DEPTH), 1'b1);
        if (imem_req) chk("req_space", (int'(occupancy) + out_tb < DEPTH), 1'b1);
        if (imem_req && imem_gnt) begin
            m.due  = cyc + lat;
            m.addr = imem_addr;
            mem_q.push_back(m);
        end
        if (redirect) begin
            chk("redir_req", imem_req, 1'b0);
            chk("redir_valid", instr_valid, 1'b0);
        end
        if (instr_valid && instr_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected cycle %0d: got pc %0h expected none", cyc, pc);
            end else begin
                e = exp_q.pop_front();
                chk("sb_pc", pc, e);
                chk("sb_instr", instr, mem_word(e));
                chk("sb_pc4", pc_plus4, e + 32'd4);
                delivered++;
            end
        end
    endtask

    task automatic end_cycle();
        if (redirect) restart_stream(redirect_pc);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int d0;

        // start-up (1-cycle memory) then stall/release; fields:
        // ready, req, addr, valid, pc, occupancy
        vecs[0]  = '{1'b1, 1'b1, 32'h00, 1'b0, 32'h00, 3'd0};
        vecs[1]  = '{1'b1, 1'b1, 32'h04, 1'b0, 32'h00, 3'd0};
        vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00, 3'd1};
        vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h04, 3'd1};
        vecs[4]  = '{1'b1, 1'b1, 32'h10, 1'b1, 32'h08, 3'd1};
        vecs[5]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h0C, 3'd1};
        vecs[6]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C, 3'd2};
        vecs[7]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 3'd3};
        vecs[8]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 3'd4};
        vecs[9]  = '{1'b0, 1'b0, 32'h00, 1'b1, 32'h0C, 3'd4};
        vecs[10] = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h0C, 3'd4};
        vecs[11] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h10, 3'd3};
        vecs[12] = '{1'b1, 1'b1, 32'h20, 1'b1, 32'h14, 3'd2};
        vecs[13] = '{1'b1, 1'b1, 32'h24, 1'b1, 32'h18, 3'd2};

        redirect    = 1'b0;
        redirect_pc = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        instr_ready = 1'b0;

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req", imem_req, 1'b0);
        chk("rst_valid", instr_valid, 1'b0);
        chk("rst_occ", occupancy, 3'd0);
        rst = 1'b1;
        cyc = 0;
        restart_stream(32'h0);

        // table: start-up latency, stall to full, release
        imem_gnt = 1'b1;
        for (int i = 0; i < 14; i++) begin
            instr_ready = vecs[i].ready;
            begin_cycle();
            chk("t_req", imem_req, vecs[i].exp_req);
            if (vecs[i].exp_req) chk("t_addr", imem_addr, vecs[i].exp_addr);
            chk("t_valid", instr_valid, vecs[i].exp_valid);
            if (vecs[i].exp_valid) chk("t_pc", pc, vecs[i].exp_pc);
            chk("t_occ", occupancy, vecs[i].exp_occ);
            end_cycle();
        end

        // sustained one instruction per cycle
        instr_ready = 1'b1;
        d0 = delivered;
        run(10);
        chk("throughput", delivered - d0, 10);

        // redirect penalty with 1-cycle memory
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        begin_cycle();
        end_cycle();
        redirect = 1'b0;
        begin_cycle();
        chk("rp_req", imem_req, 1'b1);
        chk("rp_addr", imem_addr, 32'h100);
        chk("rp_occ", occupancy, 3'd0);
        end_cycle();
        begin_cycle();
        chk("rp_valid_t2", instr_valid, 1'b0);
        end_cycle();
        begin_cycle();
        chk("rp_valid_t3", instr_valid, 1'b1);
        chk("rp_pc_t3", pc, 32'h100);
        end_cycle();

        // latency 2: redirect with responses in flight, one arriving in the redirect cycle
        lat = 2;
        run(8);
        redirect    = 1'b1;
        redirect_pc = 32'h400;
        begin_cycle();
        end_cycle();
        redirect = 1'b0;
        begin_cycle();
        chk("r2_occ", occupancy, 3'd0);
        end_cycle();
        d0 = delivered;
        run(12);
        chk("r2_delivered", delivered > d0, 1'b1);

        // latency 3 with irregular grants and consumer stalls
        lat = 3;
        d0 = delivered;
        for (int i = 0; i < 40; i++) begin
            imem_gnt    = ($urandom_range(0, 3) != 0);
            instr_ready = ($urandom_range(0, 4) != 0);
            begin_cycle();
            end_cycle();
        end
        chk("l3_delivered", delivered > d0, 1'b1);

        // two redirects on consecutive cycles: the second target wins
        imem_gnt    = 1'b1;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        begin_cycle();
        end_cycle();
        redirect_pc = 32'h300;
        begin_cycle();
        end_cycle();
        redirect = 1'b0;
        d0 = delivered;
        run(14);
        chk("bb_delivered", delivered > d0, 1'b1);

        // asynchronous reset mid-stream
        lat = 1;
        run(4);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_req", imem_req, 1'b0);
        chk("mrst_valid", instr_valid, 1'b0);
        chk("mrst_occ", occupancy, 3'd0);
        mem_q.delete();
        imem_rvalid = 1'b0;
        prev_stall  = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        restart_stream(32'h0);
        begin_cycle();
        chk("mrst_first_req", imem_req, 1'b1);
        chk("mrst_first_addr", imem_addr, 32'h0);
        end_cycle();
        d0 = delivered;
        run(10);
        chk("mrst_delivered", delivered - d0, 9);

        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
